// File: rtl/image_pkg.sv
// Shared widths, defaults and the sequencer state type for the image reader.
package image_pkg;

  localparam int IMG_ADR_W    = 19;
  localparam int PIX_W        = 8;
  localparam int N_PIXELS_DEF = 307200;
  // One extra bit so a full 2^19-pixel frame count is representable.
  localparam int CNT_W        = IMG_ADR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/image_reader_pixel_fifo.sv
// Two-entry pixel buffer between the RAM read port and the pixel stream.
// Push and pop in the same cycle keep occupancy and order unchanged.
module pixel_fifo
  import image_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PIX_W-1:0] i_data,
  output logic [PIX_W-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  logic [PIX_W-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_pop;

  // A pop on an empty buffer is ignored so pointers cannot slip.
  assign w_do_pop = i_pop & ~o_empty;

  // Storage, pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head of the buffer and status flags.
  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_empty = (r_count == 2'd0);
    o_full  = (r_count == 2'd2);
  end

endmodule

// File: rtl/image_reader.sv
// Streams one frame of N_PIXELS pixels from an image RAM (one-cycle read
// latency) starting at BASE_ADR, with at most two pixels outstanding or
// buffered at any time.
//
// Stream handshake: a pixel transfers in every cycle where pix_valid and
// pix_ready are both high. Once pix_valid rises it stays high, and pix_data
// stays unchanged, until that transfer happens; pix_ready may change freely.
module image_reader
  import image_pkg::*;
#(
  parameter logic [IMG_ADR_W-1:0] BASE_ADR = '0,
  parameter int                   N_PIXELS = N_PIXELS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IMG_ADR_W-1:0] rd_adr,
  output logic                 rd_en,
  input  logic [PIX_W-1:0]     rd_data,
  output logic [PIX_W-1:0]     pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_last,
  output state_t               o_dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_deliver_cnt;
  logic             r_inflight;

  logic             w_rd_en;
  logic             w_hs;
  logic             w_empty;
  logic             w_full;
  logic [PIX_W-1:0] w_head;
  logic [1:0]       w_occ;
  logic [1:0]       w_credit;

  // Read data lands one cycle after its request and goes straight in the buffer.
  pixel_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_pop   (w_hs),
    .i_data  (rd_data),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_hs  = ~w_empty & pix_ready;
  assign w_occ = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
  // Reads in flight plus buffered pixels, crediting a pop happening this
  // cycle: that slot is free again by the time a new read's data arrives,
  // which is what allows one read per cycle with the consumer always ready.
  assign w_credit = {1'b0, r_inflight} + w_occ - {1'b0, w_hs};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = READ;
      READ:    if (w_rd_en && (r_issue_cnt == LAST_IDX)) w_state_nxt = DRAIN;
      DRAIN:   if (w_hs && pix_last) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state, buffer status and counters.
  always_comb begin
    busy        = (r_state != IDLE);
    done        = (r_state == FINISH);
    w_rd_en     = (r_state == READ) && (w_credit < 2'd2);
    rd_en       = w_rd_en;
    rd_adr      = w_rd_en ? (BASE_ADR + r_issue_cnt[IMG_ADR_W-1:0]) : '0;
    pix_valid   = ~w_empty;
    pix_data    = w_empty ? '0 : w_head;
    pix_last    = ~w_empty && (r_deliver_cnt == LAST_IDX);
    o_dbg_state = r_state;
  end

  // Issue/deliver counters and the in-flight read marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt   <= '0;
      r_deliver_cnt <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if ((r_state == IDLE) && start) begin
        r_issue_cnt   <= '0;
        r_deliver_cnt <= '0;
      end else begin
        if (w_rd_en) r_issue_cnt   <= r_issue_cnt + CNT_W'(1);
        if (w_hs)    r_deliver_cnt <= r_deliver_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_image_reader.sv
// Bench for image_reader: three instances with different base/length,
// a RAM model returning adr[7:0], and a frame-level reference model.
module tb_image_reader;
  import image_pkg::*;

  localparam int NI = 3;

  function automatic logic [18:0] cfg_base(int g);
    case (g)
      0:       return 19'h00100;
      1:       return 19'h7FFFF;
      default: return 19'h7FFF0;
    endcase
  endfunction

  function automatic int cfg_n(int g);
    case (g)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NI-1:0]        start_w;
  logic [NI-1:0]        ready_w;
  logic [NI-1:0]        busy_w;
  logic [NI-1:0]        done_w;
  logic [NI-1:0]        rd_en_w;
  logic [NI-1:0]        valid_w;
  logic [NI-1:0]        last_w;
  logic [NI-1:0][18:0]  rd_adr_w;
  logic [NI-1:0][7:0]   rd_data_w;
  logic [NI-1:0][7:0]   pix_data_w;
  logic [NI-1:0][1:0]   dbg_w;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    image_reader #(
      .BASE_ADR (cfg_base(g)),
      .N_PIXELS (cfg_n(g))
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_w[g]),
      .busy        (busy_w[g]),
      .done        (done_w[g]),
      .rd_adr      (rd_adr_w[g]),
      .rd_en       (rd_en_w[g]),
      .rd_data     (rd_data_w[g]),
      .pix_data    (pix_data_w[g]),
      .pix_valid   (valid_w[g]),
      .pix_ready   (ready_w[g]),
      .pix_last    (last_w[g]),
      .o_dbg_state (dbg_w[g])
    );
  end

  // RAM model: data = adr[7:0] one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      rd_data_w[g] <= rd_en_w[g] ? rd_adr_w[g][7:0] : 8'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(string s, int g);
    return $sformatf("%s[%0d]", s, g);
  endfunction

  logic [7:0]  exp_q [NI][$];
  bit          m_busy       [NI];
  bit          m_done_due   [NI];
  int          m_issued     [NI];
  int          m_deliv      [NI];
  int          m_start_cyc  [NI];
  bit          m_first_seen [NI];
  bit          m_prev_stall [NI];
  logic [7:0]  m_prev_data  [NI];
  bit          rst_chk;
  int          cyc = 0;
  bit          hs, accept, done_next;
  logic [7:0]  exp_pix;
  logic [18:0] tmp_adr;

  // Reference model and checks, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      for (int g = 0; g < NI; g++) begin
        exp_q[g].delete();
        m_busy[g]       = 1'b0;
        m_done_due[g]   = 1'b0;
        m_issued[g]     = 0;
        m_deliv[g]      = 0;
        m_first_seen[g] = 1'b1;
        m_prev_stall[g] = 1'b0;
      end
      rst_chk = 1'b1;
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (rst_chk) begin
          check(tg("rst_busy", g),  32'(busy_w[g]),     32'd0);
          check(tg("rst_done", g),  32'(done_w[g]),     32'd0);
          check(tg("rst_rd_en", g), 32'(rd_en_w[g]),    32'd0);
          check(tg("rst_rd_adr", g),32'(rd_adr_w[g]),   32'd0);
          check(tg("rst_valid", g), 32'(valid_w[g]),    32'd0);
          check(tg("rst_last", g),  32'(last_w[g]),     32'd0);
          check(tg("rst_data", g),  32'(pix_data_w[g]), 32'd0);
        end
        check(tg("busy", g), 32'(busy_w[g]), 32'(m_busy[g]));
        check(tg("done", g), 32'(done_w[g]), 32'(m_done_due[g]));
        check(tg("dbg_idle", g), 32'(dbg_w[g] == 2'(IDLE)), 32'(!busy_w[g]));

        hs        = valid_w[g] & ready_w[g];
        done_next = 1'b0;

        if (valid_w[g]) begin
          if (!m_first_seen[g]) begin
            // start sampled at edge k, first pixel visible after edge k+2
            check(tg("latency", g), 32'(cyc - m_start_cyc[g]), 32'd3);
            m_first_seen[g] = 1'b1;
          end
          if (exp_q[g].size() == 0)
            check(tg("spurious_valid", g), 32'd1, 32'd0);
          else
            check(tg("pix_last", g), 32'(last_w[g]), 32'(exp_q[g].size() == 1));
        end

        if (m_prev_stall[g]) begin
          check(tg("stall_valid", g), 32'(valid_w[g]), 32'd1);
          check(tg("stall_data", g), 32'(pix_data_w[g]), 32'(m_prev_data[g]));
        end

        if (rd_en_w[g]) begin
          check(tg("rd_in_frame", g), 32'(m_busy[g] && (m_issued[g] < cfg_n(g))), 32'd1);
          tmp_adr = cfg_base(g) + 19'(m_issued[g]);
          check(tg("rd_adr", g), 32'(rd_adr_w[g]), 32'(tmp_adr));
          m_issued[g]++;
        end

        if (hs && exp_q[g].size() > 0) begin
          exp_pix = exp_q[g].pop_front();
          check(tg("pix_data", g), 32'(pix_data_w[g]), 32'(exp_pix));
          m_deliv[g]++;
          if (exp_q[g].size() == 0) done_next = 1'b1;
        end

        check(tg("outstanding", g), 32'((m_issued[g] - m_deliv[g]) <= 2), 32'd1);

        m_prev_stall[g] = valid_w[g] & ~ready_w[g];
        m_prev_data[g]  = pix_data_w[g];

        accept = start_w[g] & ~m_busy[g];
        if (m_done_due[g]) m_busy[g] = 1'b0;
        m_done_due[g] = done_next;
        if (accept) begin
          m_busy[g]       = 1'b1;
          m_issued[g]     = 0;
          m_deliv[g]      = 0;
          m_start_cyc[g]  = cyc;
          m_first_seen[g] = 1'b0;
          for (int i = 0; i < cfg_n(g); i++) begin
            tmp_adr = cfg_base(g) + 19'(i);
            exp_q[g].push_back(tmp_adr[7:0]);
          end
        end
      end
      rst_chk = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(int max_cyc);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < max_cyc) begin
      tick();
      @(negedge clk);
      idle = (busy_w == '0);
      n++;
    end
    check("idle_timeout", 32'(idle), 32'd1);
  endtask

  initial begin
    bit seen;
    int hs_cnt;
    reset   = 1'b1;
    start_w = '0;
    ready_w = '0;
    repeat (4) tick();
    reset = 1'b0;
    tick();

    // Full throughput, plus starts while busy and in the done cycle.
    ready_w = '1;
    start_w[0] = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start_w[0] = (k == 3) || (k == 7);
      @(negedge clk);
      if (done_w[0] && !seen) begin
        check("t1_done_cycle", 32'(k), 32'd7);
        seen = 1'b1;
      end
    end
    start_w[0] = 1'b0;
    check("t1_done_seen", 32'(seen), 32'd1);
    wait_idle(20);

    // Consumer ready pattern 1,0,0,1,0,0,...
    tick();
    start_w[0] = 1'b1;
    ready_w[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start_w[0] = 1'b0;
      ready_w[0] = ((k % 3) == 0);
    end
    ready_w[0] = 1'b1;
    wait_idle(40);

    // Single-pixel frame at the top of the address space.
    tick();
    start_w[1] = 1'b1;
    tick();
    start_w[1] = 1'b0;
    wait_idle(40);

    // Reset after the second pixel of a frame, then a fresh frame.
    tick();
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    hs_cnt = 0;
    for (int k = 0; k < 20 && hs_cnt < 2; k++) begin
      @(negedge clk);
      if (valid_w[0] && ready_w[0]) hs_cnt++;
      if (hs_cnt < 2) tick();
    end
    check("t4_two_handshakes", 32'(hs_cnt), 32'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    wait_idle(40);

    // Random starts and back-pressure on all instances.
    for (int k = 0; k < 1500; k++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        ready_w[g] = ($urandom_range(0, 3) != 0);
        start_w[g] = ($urandom_range(0, 15) == 0);
      end
    end
    tick();
    start_w = '0;
    ready_w = '1;
    wait_idle(200);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_reader.md
IMAGE_READER -- requirements
Module: image_reader

Interface
REQ-001 Parameter BASE_ADR, default 19'h00000; first pixel address read.
REQ-002 Parameter N_PIXELS, default 307200; number of pixels streamed per frame, range 1..2^19-BASE_ADR.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to stream one frame.
REQ-006 busy  out  1  high from accepted start until done.
REQ-007 done  out  1  one-cycle pulse after last pixel handshake.
REQ-008 rd_adr  out  19  image RAM read address.
REQ-009 rd_en  out  1  read request; RAM returns rd_data exactly one cycle later.
REQ-010 rd_data  in  8  image RAM read data.
REQ-011 pix_data  out  8  streamed pixel.
REQ-012 pix_valid  out  1  pix_data valid.
REQ-013 pix_ready  in  1  consumer accepts; handshake = pix_valid & pix_ready.
REQ-014 pix_last  out  1  high with the final pixel of the frame.

Function
REQ-015 FSM states IDLE, READ, DRAIN, FINISH.
REQ-016 IDLE: start -> READ, issue counter = 0, deliver counter = 0; start ignored in any other state.
REQ-017 READ: rd_en = 1 when (reads in flight + buffered pixels) < 2; rd_adr = BASE_ADR + issue counter; issue counter increments per rd_en.
REQ-018 READ -> DRAIN in the cycle the N_PIXELS-th read is issued; no rd_en in DRAIN, FINISH or IDLE.
REQ-019 rd_data captured into a 2-entry FIFO one cycle after each rd_en; FIFO never overflows under REQ-017.
REQ-020 pix_valid = FIFO not empty; pix_data = FIFO head; head pops on handshake.
REQ-021 pix_data and pix_valid hold stable while pix_valid & !pix_ready.
REQ-022 pix_last = pix_valid & (deliver counter == N_PIXELS-1).
REQ-023 Deliver counter increments per handshake; handshake with pix_last -> FINISH.
REQ-024 FINISH: done = 1 for exactly one cycle, then IDLE; busy = 0 in IDLE only.
REQ-025 Full throughput: with pix_ready held high, one pixel per cycle after 2-cycle initial latency (start to first pix_valid).
REQ-026 Simultaneous FIFO push and pop in one cycle: occupancy unchanged, order preserved.
REQ-027 N_PIXELS = 1: one read, pix_last with first pixel.
REQ-028 Address never exceeds BASE_ADR + N_PIXELS - 1; no wrap-around.
REQ-029 start coincident with done cycle ignored; new frame needs start while in IDLE.

Reset
REQ-030 reset (any state, mid-frame included) -> IDLE, counters 0, FIFO empty, in-flight read discarded.
REQ-031 Output values during/after reset: busy 0, done 0, rd_en 0, rd_adr 0, pix_valid 0, pix_last 0, pix_data 0.

Structure
REQ-032 Package image_pkg holds IMG_ADR_W = 19, PIX_W = 8, default N_PIXELS, and the state enum typedef.
REQ-033 Sub-module pixel_fifo: 2-entry, PIX_W wide, synchronous, with push/pop/empty/full; instantiated once.

Verification
REQ-034 BASE_ADR=0x100, N_PIXELS=4, RAM model data = adr[7:0], pix_ready=1, start pulse -> rd_adr 0x100..0x103 on consecutive cycles, pix_data 00,01,02,03 on consecutive cycles, pix_last on 03, done one cycle later.
REQ-035 Same setup, pix_ready toggling 1,0,0,1,... -> stream still 00..03 in order, no drop/duplicate, at most 2 reads outstanding+buffered, pix_data stable while stalled.
REQ-036 N_PIXELS=1, BASE_ADR=0x7FFFF -> single read at 0x7FFFF, pix_valid and pix_last together, done pulse, busy low after.
REQ-037 reset asserted after 2nd handshake of a 4-pixel frame -> next cycle all outputs at reset values; new start reads again from 0x100.
REQ-038 start pulsed while busy and in done cycle -> ignored; no extra frame, exactly one done per accepted start.
